// File: rtl/sparse_rf_encoder_if.sv
// rtl/sparse_rf_encoder_if.sv - stream-in / filter-table-out bundle for the RF run-length encoder
interface sparse_rf_encoder_if #(
  parameter int K     = 4,
  parameter int LEN_W = 11
);
  localparam int RUNS_W = $clog2(K + 1);

  logic                    i_start;
  logic                    i_valid;
  logic [2:0]              i_r;
  logic [4:0]              i_k;
  logic                    i_last;
  logic                    o_ready;
  logic [K-1:0][2:0]       o_r;
  logic [K-1:0][4:0]       o_k;
  logic [K-1:0][LEN_W-1:0] o_ptr;
  logic [RUNS_W-1:0]       o_runs;
  logic [LEN_W-1:0]        o_length;
  logic                    o_overflow;
  logic                    o_finish;

  modport master (
    output i_start, i_valid, i_r, i_k, i_last,
    input  o_ready, o_r, o_k, o_ptr, o_runs, o_length, o_overflow, o_finish
  );

  modport slave (
    input  i_start, i_valid, i_r, i_k, i_last,
    output o_ready, o_r, o_k, o_ptr, o_runs, o_length, o_overflow, o_finish
  );
endinterface

// File: rtl/sparse_rf_encoder.sv
// rtl/sparse_rf_encoder.sv - run-length encodes (r,k) entries into a K-deep (r,k,ptr) filter table
module sparse_rf_encoder #(
  parameter int K     = 4,
  parameter int LEN_W = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sparse_rf_encoder_if.slave   bus
);
  localparam int              RUNS_W  = $clog2(K + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [K-1:0][2:0]       r_r;
  logic [K-1:0][4:0]       r_k;
  logic [K-1:0][LEN_W-1:0] r_ptr;
  logic [RUNS_W-1:0]       r_runs;
  logic [LEN_W-1:0]        r_length;
  logic                    r_overflow;
  logic                    w_accept;
  logic                    w_new_run;
  logic [2:0]              w_last_r;
  logic [4:0]              w_last_k;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.o_ready  = 1'b0;
    bus.o_finish = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.i_start) w_next = S_COLLECT;
      S_COLLECT: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid && bus.i_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.o_finish = 1'b1;
        w_next       = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_COLLECT) && bus.i_valid;

  // Only the most recently stored run is a merge candidate.
  always_comb begin
    w_last_r = '0;
    w_last_k = '0;
    for (int i = 0; i < K; i++) begin
      if (r_runs == RUNS_W'(i + 1)) begin
        w_last_r = r_r[i];
        w_last_k = r_k[i];
      end
    end
  end

  assign w_new_run = (r_runs == '0) || (bus.i_r != w_last_r) || (bus.i_k != w_last_k);

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == S_IDLE && bus.i_start)) begin
      r_r        <= '0;
      r_k        <= '0;
      r_ptr      <= '0;
      r_runs     <= '0;
      r_length   <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if (r_length == LEN_MAX) begin
        r_overflow <= 1'b1;
      end else begin
        r_length <= r_length + 1'b1;
        if (w_new_run && r_runs == RUNS_W'(K)) begin
          r_overflow <= 1'b1;
        end else if (!r_overflow) begin
          // Once overflowed the table freezes, so merges into a dropped run never land.
          for (int i = 0; i < K; i++) begin
            if (w_new_run && r_runs == RUNS_W'(i)) begin
              r_r[i]   <= bus.i_r;
              r_k[i]   <= bus.i_k;
              r_ptr[i] <= r_length + 1'b1;
            end
            if (!w_new_run && r_runs == RUNS_W'(i + 1)) r_ptr[i] <= r_ptr[i] + 1'b1;
          end
          if (w_new_run) r_runs <= r_runs + 1'b1;
        end
      end
    end
  end

  assign bus.o_r        = r_r;
  assign bus.o_k        = r_k;
  assign bus.o_ptr      = r_ptr;
  assign bus.o_runs     = r_runs;
  assign bus.o_length   = r_length;
  assign bus.o_overflow = r_overflow;
endmodule

// File: doc/sparse_rf_encoder.md
Name: sparse_rf_encoder

Overview:
- Run-length encodes a stream of RF address entries into the compressed filter table (r, k, ptr) that the address generator consumes.
- Each input entry carries a row offset r and a channel index k. Consecutive entries with identical (r, k) collapse into one run.
- Each run is described by its r, its k and an exclusive end pointer, which is the cumulative entry count.
- Sits between the weight-preprocessing stream and the address generator's i_r/i_k/i_ptr/i_length inputs.

Parameters:
- K, 4, maximum number of runs stored in the table.
- LEN_W, 11, width of the length and pointer fields; maximum stream length is 2^LEN_W-1 = 2047.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  single-cycle pulse that begins a new encode; honoured only in IDLE.
- i_valid  input  1  entry present on i_r/i_k/i_last.
- i_r  input  3  row offset of the entry.
- i_k  input  5  channel index of the entry.
- i_last  input  1  marks the final entry of the stream; qualified by i_valid.
- o_ready  output  1  high in COLLECT; an entry is accepted when i_valid && o_ready.
- o_r  output  K x 3  run row offsets.
- o_k  output  K x 5  run channel indices.
- o_ptr  output  K x LEN_W  exclusive end index of each run.
- o_runs  output  3  number of valid runs, 0..K.
- o_length  output  LEN_W  total accepted entries.
- o_overflow  output  1  sticky flag: run table full or length saturated during this encode.
- o_finish  output  1  one-cycle pulse; the table is complete.

Behaviour:
- Reset (i_rst high at a clock edge) has priority over all other inputs and applies in any state, including mid-encode.
  - State goes to IDLE; o_ready=0 and o_finish=0.
  - o_r, o_k, o_ptr all entries = 0; o_runs=0, o_length=0, o_overflow=0.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - o_ready=0; all outputs hold their previous values.
  - On i_start: clear the table, o_runs, o_length and o_overflow; next state is COLLECT.
- COLLECT:
  - o_ready=1; i_start is ignored.
  - Cycles with i_valid=0 leave all state unchanged.
- On an accepted entry in COLLECT:
  - New run: taken when o_runs==0, or when (i_r,i_k) differs from (o_r[o_runs-1], o_k[o_runs-1]).
    - If o_runs<K: write o_r[o_runs]=i_r, o_k[o_runs]=i_k and o_ptr[o_runs]=o_length+1, then increment o_runs.
    - If o_runs==K: set o_overflow; the table is unchanged.
  - Same as the current run: increment o_ptr[o_runs-1], but only if that run was not dropped.
    - A run is dropped when it starts while overflow is set.
    - Entries after overflow never modify stored runs; o_ptr[K-1] freezes.
  - o_length increments on every accepted entry.
  - At o_length == 2^LEN_W-1, further entries are discarded: no length or table change, o_overflow set.
  - Accepted entry with i_last=1: next state is DONE.
- Matching rule: the run comparison uses only the immediately preceding stored run. A non-adjacent repeat of a (r,k) pair opens a new run.
- Invariants:
  - o_ptr strictly increasing over 0..o_runs-1.
  - o_ptr[o_runs-1]==o_length whenever o_overflow==0.
  - Unused entries (index >= o_runs) read 0.
- DONE:
  - o_finish=1 for exactly one cycle; o_ready=0.
  - Next state is IDLE; the table holds until the next i_start or reset.
- Latency: o_finish is asserted in the cycle after the edge that accepts the i_last entry. Table outputs are registered and final in that same cycle.
- A stream containing only one entry completes with o_runs=1, o_ptr[0]=1, o_length=1.

Test Plan:
- Basic encode, contiguous valid:
  - Stimulus: i_start, then (r,k) = (0,1)x3, (2,4)x2, (1,0)x1, with i_last on the 6th entry.
  - Response: o_finish one cycle after the 6th entry; o_runs=3, o_r={0,2,1,0}, o_k={1,4,0,0}, o_ptr={3,5,6,0}, o_length=6, o_overflow=0.
- Valid gaps:
  - Stimulus: same stream as the basic encode, with i_valid low for 2 cycles between every entry.
  - Response: identical table; o_finish one cycle after the last accept.
- Non-adjacent repeat:
  - Stimulus: (3,7), (5,2), (3,7) with last.
  - Response: o_runs=3, o_ptr={1,2,3,0}, o_length=3.
- Overflow:
  - Stimulus: 6 distinct single-entry runs, then 2 more entries equal to the 6th.
  - Response: o_runs=4, o_ptr={1,2,3,4}, o_length=8, o_overflow=1; o_ptr[3] stays 4.
- Reset mid-operation:
  - Stimulus: i_rst after 2 accepted entries.
  - Response: next cycle IDLE, o_ready=0, all outputs 0. A subsequent i_start plus a single entry (6,31) with last gives o_runs=1, o_r[0]=6, o_k[0]=31, o_ptr[0]=1.
- i_start ignored in COLLECT:
  - Stimulus: i_start pulsed while in COLLECT after 1 accepted entry.
  - Response: o_length is not cleared and the encode continues unchanged.
